vending_controller: RTL

//  Parametrised vending FSM for N_ITEMS products with per-item price, per-item stock

---
 rtl/vending_controller_pkg.sv | 11 +
 rtl/vend_stock_bank.sv | 53 +++++
 rtl/vending_controller.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/vending_controller_pkg.sv
// Shared types for the vending controller: FSM state encoding.
package vending_controller_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_COIN = 2'd1,
    VEND      = 2'd2,
    REFUND    = 2'd3
  } vend_state_t;

endpackage

// File: rtl/vend_stock_bank.sv
// Per-item stock counters with a vend decrement port, a saturating restock port
// and the sold_out flags derived from the counters.
module vend_stock_bank #(
  parameter int N_ITEMS    = 4,
  parameter int IDX_W      = 2,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dec_valid,
  input  logic [IDX_W-1:0]   dec_idx,
  input  logic               restock_valid,
  input  logic [IDX_W-1:0]   restock_idx,
  input  logic [STOCK_W-1:0] restock_qty,
  output logic [N_ITEMS-1:0] sold_out
);

  logic [STOCK_W-1:0] stock [N_ITEMS];

  // Add first, then take one away, so a same-cycle restock and vend net out before saturation.
  function automatic logic [STOCK_W-1:0] stock_update(
    input logic [STOCK_W-1:0] cur,
    input logic               add_en,
    input logic [STOCK_W-1:0] qty,
    input logic               sub_en
  );
    logic [STOCK_W:0] t;
    t = {1'b0, cur} + (add_en ? {1'b0, qty} : '0);
    if (sub_en && (t != '0))
      t = t - 1'b1;
    return t[STOCK_W] ? '1 : t[STOCK_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_ITEMS; i++) begin
      if (rst)
        stock[i] <= STOCK_W'(STOCK_INIT);
      else
        stock[i] <= stock_update(stock[i],
                                 restock_valid && (restock_idx == IDX_W'(i)),
                                 restock_qty,
                                 dec_valid && (dec_idx == IDX_W'(i)));
    end
  end

  always_comb begin
    sold_out = '0;
    for (int i = 0; i < N_ITEMS; i++)
      sold_out[i] = (stock[i] == '0);
  end

endmodule

// File: rtl/vending_controller.sv
// Vending FSM: item selection, coin credit accumulation, vend with change,
// cancel/timeout refund. All dispense, change and refund outputs are registered pulses.
module vending_controller
  import vending_controller_pkg::*;
#(
  parameter int                          N_ITEMS    = 4,
  parameter int                          IDX_W      = 2,
  parameter int                          CREDIT_W   = 4,
  parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES     = {4'd6, 4'd5, 4'd4, 4'd3},
  parameter int                          STOCK_W    = 4,
  parameter int                          STOCK_INIT = 4,
  parameter int                          TIMEOUT    = 255,
  parameter int                          TMO_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sel_valid,
  input  logic [IDX_W-1:0]    sel_idx,
  input  logic                coin_valid,
  input  logic [CREDIT_W-1:0] coin_val,
  input  logic                cnl,
  input  logic                restock_valid,
  input  logic [IDX_W-1:0]    restock_idx,
  input  logic [STOCK_W-1:0]  restock_qty,
  output logic                pdt,
  output logic [IDX_W-1:0]    pdt_idx,
  output logic [CREDIT_W-1:0] cng,
  output logic [CREDIT_W-1:0] rtn,
  output logic                rtn_valid,
  output logic                sel_reject,
  output logic                coin_reject,
  output logic                busy,
  output logic [N_ITEMS-1:0]  sold_out
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  function automatic logic [CREDIT_W-1:0] get_price(
    input logic [N_ITEMS*CREDIT_W-1:0] p,
    input logic [IDX_W-1:0]            i
  );
    return p[int'(i)*CREDIT_W +: CREDIT_W];
  endfunction

  vend_state_t         state;
  logic [IDX_W-1:0]    idx;
  logic [CREDIT_W-1:0] credit;
  logic [TMO_W-1:0]    timer;
  logic [CREDIT_W-1:0] price;
  logic [CREDIT_W:0]   credit_sum;
  logic [CREDIT_W-1:0] credit_nxt;
  logic                coin_live;
  logic                coin_fits;
  logic                sel_ok;

  assign price      = get_price(PRICES, idx);
  assign coin_live  = coin_valid && (coin_val != '0);
  assign credit_sum = {1'b0, credit} + {1'b0, coin_val};
  // A coin that would wrap the credit register is bounced back to the customer.
  assign coin_fits  = coin_live && !credit_sum[CREDIT_W];
  assign credit_nxt = coin_fits ? credit_sum[CREDIT_W-1:0] : credit;
  assign sel_ok     = (int'(sel_idx) < N_ITEMS) && !sold_out[sel_idx];
  assign busy       = (state != IDLE);

  vend_stock_bank #(
    .N_ITEMS   (N_ITEMS),
    .IDX_W     (IDX_W),
    .STOCK_W   (STOCK_W),
    .STOCK_INIT(STOCK_INIT)
  ) u_stock (
    .clk          (clk),
    .rst          (rst),
    .dec_valid    (state == VEND),
    .dec_idx      (idx),
    .restock_valid(restock_valid),
    .restock_idx  (restock_idx),
    .restock_qty  (restock_qty),
    .sold_out     (sold_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      credit      <= '0;
      timer       <= '0;
      pdt         <= 1'b0;
      pdt_idx     <= '0;
      cng         <= '0;
      rtn         <= '0;
      rtn_valid   <= 1'b0;
      sel_reject  <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      pdt         <= 1'b0;
      pdt_idx     <= '0;
      cng         <= '0;
      rtn         <= '0;
      rtn_valid   <= 1'b0;
      sel_reject  <= 1'b0;
      coin_reject <= 1'b0;
      case (state)
        IDLE: begin
          coin_reject <= coin_live;
          if (sel_valid) begin
            if (sel_ok) begin
              idx    <= sel_idx;
              credit <= '0;
              timer  <= '0;
              state  <= WAIT_COIN;
            end else begin
              sel_reject <= 1'b1;
            end
          end
        end
        WAIT_COIN: begin
          credit      <= credit_nxt;
          coin_reject <= coin_live && !coin_fits;
          timer       <= coin_fits ? '0 : timer + 1'b1;
          // Cancel outranks reaching the price; the accepted coin joins the refund.
          if (cnl)
            state <= REFUND;
          else if (credit_nxt >= price)
            state <= VEND;
          else if (!coin_fits && (timer == TMO_LAST))
            state <= REFUND;
        end
        VEND: begin
          coin_reject <= coin_live;
          pdt         <= 1'b1;
          pdt_idx     <= idx;
          cng         <= credit - price;
          credit      <= '0;
          state       <= IDLE;
        end
        REFUND: begin
          coin_reject <= coin_live;
          rtn_valid   <= 1'b1;
          rtn         <= credit;
          credit      <= '0;
          state       <= IDLE;
        end
        default: begin
          credit <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
